// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the loadable down-timer.
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 5;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter / one-shot timer with a registered terminal-count pulse.
// Define AUTO_RELOAD_EN for periodic operation (reload on terminal count instead of stopping).
//
// state | meaning
// IDLE  | stopped, count held, waiting for a load
// RUN   | counting down while enab is high
// DONE  | terminal count reached, count is 0, waiting for clr or load
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_d;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reload_q <= '0;
    else      reload_q <= reload_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_out <= '0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_out <= cnt_d;
      tc      <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_out;
    tc_d    = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      cnt_d = cnt_in;
`ifdef AUTO_RELOAD_EN
      reload_d = cnt_in;
`endif
      if (cnt_in != '0) begin
        state_d = RUN;
      end else begin
        state_d = DONE;
        tc_d    = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (enab) begin
            if (cnt_out > WIDTH'(1)) begin
              cnt_d = cnt_out - WIDTH'(1);
            end else begin
              // terminal count: stop at zero, or restart from the loaded period
`ifdef AUTO_RELOAD_EN
              cnt_d = reload_q;
`else
              cnt_d   = '0;
              state_d = DONE;
`endif
              tc_d = 1'b1;
            end
          end
        end
        DONE: begin
          cnt_d = '0;
          if (clr) state_d = IDLE;
        end
        IDLE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: cycle-by-cycle model comparison plus directed literal checks.
module tb_down_timer;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic         enab = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] cnt_in = '0;
  logic [W-1:0] cnt_out;
  logic         tc;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  down_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .enab(enab), .clr(clr),
    .cnt_in(cnt_in), .cnt_out(cnt_out), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: a count value plus "running"/"finished" flags and a pulse flag.
  int m_cnt      = 0;
  int m_period   = 0;
  bit m_running  = 0;
  bit m_finished = 0;
  bit m_pulse    = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_period = 0; m_running = 0; m_finished = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (load) begin
        m_cnt    = int'(cnt_in);
        m_period = int'(cnt_in);
        m_running  = (cnt_in != 0);
        m_finished = (cnt_in == 0);
        m_pulse    = (cnt_in == 0);
      end else if (m_finished) begin
        if (clr) m_finished = 0;
      end else if (m_running && enab) begin
        if (m_cnt == 1) begin
          m_pulse = 1;
`ifdef AUTO_RELOAD_EN
          m_cnt = m_period;
`else
          m_cnt = 0;
          m_running = 0;
          m_finished = 1;
`endif
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("model_cnt",  int'(cnt_out), m_cnt);
      chk("model_tc",   int'(tc),      int'(m_pulse));
      chk("model_busy", int'(busy),    int'(m_running));
      chk("model_done", int'(done),    int'(m_finished));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input int c, input int t, input int b, input int d);
    chk({name, "_cnt"},  int'(cnt_out), c);
    chk({name, "_tc"},   int'(tc),      t);
    chk({name, "_busy"}, int'(busy),    b);
    chk({name, "_done"}, int'(done),    d);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 lit("reset", 0, 0, 0, 0);
    tick();
    rst = 1'b1;

`ifndef AUTO_RELOAD_EN
    // load 3 and count out
    load = 1; cnt_in = 5'h03; tick();
    lit("t1_load", 3, 0, 1, 0);
    load = 0; enab = 1; tick();
    lit("t1_c2", 2, 0, 1, 0);
    tick(); lit("t1_c1", 1, 0, 1, 0);
    tick(); lit("t1_c0", 0, 1, 0, 1);
    tick(); lit("t1_hold", 0, 0, 0, 1);
    clr = 1; tick(); lit("t1_clr", 0, 0, 0, 0);
    clr = 0;

    // pause
    load = 1; cnt_in = 5'h05; tick();
    load = 0; tick(); lit("t2_c4", 4, 0, 1, 0);
    enab = 0;
    repeat (3) tick();
    lit("t2_pause", 4, 0, 1, 0);
    clr = 1; tick(); lit("t2_clr_run", 4, 0, 1, 0);
    clr = 0; enab = 1; tick(); lit("t2_resume", 3, 0, 1, 0);
    repeat (3) tick();
    lit("t2_end", 0, 1, 0, 1);
    clr = 1; tick(); clr = 0;

    // zero load
    load = 1; cnt_in = 5'h00; tick();
    lit("t3_zero", 0, 1, 0, 1);
    load = 0; tick(); lit("t3_after", 0, 0, 0, 1);

    // load beats clr in DONE; reload mid-count
    load = 1; clr = 1; cnt_in = 5'h1F; tick();
    lit("t4_prio", 31, 0, 1, 0);
    load = 0; clr = 0; tick(); tick();
    lit("t4_c1d", 29, 0, 1, 0);
    load = 1; cnt_in = 5'h0A; tick();
    lit("t4_reload", 10, 0, 1, 0);
    load = 0;
`endif

    // async reset mid-run
    load = 1; cnt_in = 5'h07; enab = 1; tick();
    load = 0;
    lit("t5_pre", 7, 0, 1, 0);
    #3 rst = 1'b0;
    #1 lit("t5_async", 0, 0, 0, 0);
    tick();
    rst = 1'b1; enab = 1;
    tick(); tick();
    lit("t5_idle", 0, 0, 0, 0);

`ifdef AUTO_RELOAD_EN
    load = 1; cnt_in = 5'h02; tick();
    lit("t6_load", 2, 0, 1, 0);
    load = 0; tick(); lit("t6_c1", 1, 0, 1, 0);
    tick(); lit("t6_rl1", 2, 1, 1, 0);
    tick(); lit("t6_c1b", 1, 0, 1, 0);
    tick(); lit("t6_rl2", 2, 1, 1, 0);
    repeat (5) tick();
    load = 1; cnt_in = 5'h00; tick();
    lit("t6_zero", 0, 1, 0, 1);
    load = 0; clr = 1; tick();
    lit("t6_clr", 0, 0, 0, 0);
    clr = 0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counter and one-shot timer. It is the counting-down counterpart to the team's loadable up-counter.
- Takes a start value on `load` and decrements while `enab` is high.
- Flags terminal count with a one-cycle `tc` pulse and a sticky `done` level, which is cleared by `clr`.
- Used as a programmable delay/timeout source by control blocks that already drive the up-counter's load/enab interface.

Parameters:
WIDTH, 5, bit width of the count value, the load value and the internal reload register

Ports:
clk     input   1      system clock; all state updates on rising edge
rst     input   1      reset; one clock; reset is asynchronous and active-low
load    input   1      load cnt_in into counter and reload register; highest priority after reset
enab    input   1      count enable; decrement only when high and state is RUN
clr     input   1      acknowledge/clear of done; returns DONE to IDLE
cnt_in  input   WIDTH  start value sampled when load=1
cnt_out output  WIDTH  current count, registered
tc      output  1      terminal-count pulse, one cycle, registered
busy    output  1      high while state is RUN
done    output  1      high while state is DONE

Behaviour:
- Reset (rst=0, asynchronous):
  - cnt_out=0, tc=0, busy=0, done=0, reload_reg=0, state=IDLE.
  - Takes effect immediately, including mid-count; no pending tc survives.
- State machine: IDLE, RUN, DONE. busy and done are decoded directly from state.
- Priority at each edge: load > clr > count.
- load=1, any state:
  - cnt_out<=cnt_in and reload_reg<=cnt_in.
  - Next state is RUN if cnt_in!=0.
  - If cnt_in==0: next state is DONE and tc=1 in the following cycle.
- RUN, no load:
  - enab=1 and cnt_out>1: cnt_out<=cnt_out-1.
  - enab=1 and cnt_out==1: cnt_out<=0, next state DONE, tc=1 for the following cycle only.
  - enab=0: hold value and state.
- DONE:
  - cnt_out holds 0 and done=1.
  - clr=1 (no load): next state IDLE, done=0.
  - enab is ignored.
- IDLE: hold cnt_out; enab and clr are ignored.
- clr in IDLE or RUN: no effect.
- No wrap: cnt_out never decrements below 0 and never underflows to all-ones.
- tc is registered; it is high exactly one cycle per terminal event, and low in every other cycle.
- Latency: load to cnt_out is 1 edge; a load of N with enab held high reaches 0 after N further edges.

Optional Feature:
Macro: AUTO_RELOAD_EN
- Defined: in RUN with enab=1 and cnt_out==1, cnt_out<=reload_reg, state stays RUN, and tc pulses for one cycle.
  - Gives a periodic tc with period reload_reg cycles.
  - DONE is reachable only via a load of 0.
  - clr still exits DONE to IDLE.
- Undefined: one-shot behaviour as above. reload_reg may be optimised away, but cnt_out behaviour is unchanged.

Decomposition:
- Package down_timer_pkg holds:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - DEFAULT_WIDTH=5.
- No sub-module. The block is a single module containing the FSM, the count register, the reload register and the tc register.

Test Plan:
1. Load and count out: WIDTH=5, load=1 cnt_in=5'h03, then load=0 enab=1 → cnt_out 03,02,01,00 on successive edges; busy=1 until cnt_out=00; tc=1 only in the 00 cycle; done=1 afterwards, then clr=1 → IDLE, done=0.
2. Pause: load 5'h05, count to 04, enab=0 for 3 cycles → cnt_out stays 04, tc=0; enab=1 → resumes at 03.
3. Zero load: load 5'h00 → next cycle cnt_out=00, done=1, tc=1 for one cycle, busy=0.
4. Priority and reload: in DONE, assert load=1 with cnt_in=5'h1F and clr=1 on the same edge → load wins: cnt_out=1F, state RUN; a further load of 5'h0A mid-count → cnt_out=0A next edge.
5. Async reset mid-run: at cnt_out=5'h07 drive rst=0 between edges → cnt_out, tc, busy, done go to 0 immediately; after release, enab=1 alone keeps cnt_out=00 in IDLE.
6. AUTO_RELOAD_EN defined: load 5'h02, enab=1 → cnt_out 02,01,02,01,…; tc high in each cycle where cnt_out returns to 02; done never asserts.
